// File: rtl/serial_mag_comp.sv
// serial_mag_comp: bit-serial magnitude comparator over framed bit pairs.
// Compares operand A against B one (a,b) bit pair per accepted beat.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready beat handshake; in_ready is low only while a result waits
//   in_a, in_b        operand bits for this beat
//   in_last           closes the frame on this beat
//   res_valid/ready   result handshake toward the sink
//   res_gt/eq/lt      one-hot frame decision (A>B, A==B, A<B)
//   res_nbits         beats in the frame, closing beat included
//   res_err           frame was force-closed at MAX_BITS without in_last
//
// Parameters:
//   MAX_BITS          longest frame; the beat that reaches it closes the frame
//   LSB_FIRST         0: frames arrive MSB first, 1: LSB first
module serial_mag_comp #(
    parameter int MAX_BITS  = 16,
    parameter bit LSB_FIRST = 1'b0,
    localparam int NB_W     = $clog2(MAX_BITS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_a,
    input  logic            in_b,
    input  logic            in_last,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_gt,
    output logic            res_eq,
    output logic            res_lt,
    output logic [NB_W-1:0] res_nbits,
    output logic            res_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        D_NONE = 2'd0,
        D_GT   = 2'd1,
        D_LT   = 2'd2
    } dec_t;

    state_t          r_state;
    state_t          w_state_nxt;
    dec_t            r_dec;
    dec_t            w_bit_dec;
    dec_t            w_dec_nxt;
    logic [NB_W-1:0] r_cnt;
    logic [NB_W-1:0] w_cnt_inc;
    logic            w_accept;
    logic            w_at_max;
    logic            w_close;
    logic            w_release;

    logic            r_gt;
    logic            r_eq;
    logic            r_lt;
    logic [NB_W-1:0] r_nbits;
    logic            r_err;

    // ---------------------------------------------------------------
    // Beat-level datapath
    // ---------------------------------------------------------------
    assign w_accept  = in_valid & in_ready;
    assign w_release = res_valid & res_ready;
    assign w_cnt_inc = r_cnt + NB_W'(1);
    assign w_at_max  = (w_cnt_inc == NB_W'(MAX_BITS));
    assign w_close   = w_accept & (in_last | w_at_max);

    // One-bit compare of the current pair.
    always_comb begin
        w_bit_dec = D_NONE;
        unique case (1'b1)
            (in_a & ~in_b): w_bit_dec = D_GT;
            (~in_a & in_b): w_bit_dec = D_LT;
            default:        w_bit_dec = D_NONE;
        endcase
    end

    // MSB first: the first differing bit is the most significant one,
    // so it wins and sticks. LSB first: the latest differing bit is
    // the most significant seen so far, so it overwrites.
    always_comb begin
        w_dec_nxt = r_dec;
        if (LSB_FIRST) begin
            if (w_bit_dec != D_NONE) begin
                w_dec_nxt = w_bit_dec;
            end
        end else begin
            if (r_dec == D_NONE) begin
                w_dec_nxt = w_bit_dec;
            end
        end
    end

    // Running count/decision. They are cleared when the result leaves,
    // so IDLE always starts a frame from count 0 and no decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_dec <= D_NONE;
        end else if (w_release) begin
            r_cnt <= '0;
            r_dec <= D_NONE;
        end else if (w_accept) begin
            r_cnt <= w_cnt_inc;
            r_dec <= w_dec_nxt;
        end
    end

    // Result registers load on the closing edge and then hold, which
    // keeps them stable for as long as the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_nbits <= '0;
            r_err   <= 1'b0;
        end else if (w_close) begin
            r_gt    <= (w_dec_nxt == D_GT);
            r_eq    <= (w_dec_nxt == D_NONE);
            r_lt    <= (w_dec_nxt == D_LT);
            r_nbits <= w_cnt_inc;
            r_err   <= ~in_last;
        end
    end

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_ACC: begin
                if (w_accept) begin
                    w_state_nxt = w_close ? S_DONE : S_ACC;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b1;
        res_valid = 1'b0;
        unique case (r_state)
            S_DONE: begin
                in_ready  = 1'b0;
                res_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                res_valid = 1'b0;
            end
        endcase
    end

    assign res_gt    = r_gt;
    assign res_eq    = r_eq;
    assign res_lt    = r_lt;
    assign res_nbits = r_nbits;
    assign res_err   = r_err;

endmodule
